debug_input: RTL and testbench

//   Host-to-CPU debug byte channel; the receive-side counterpart of the debug output port.
//   An external source (host bridge or testbench) presents bytes as a one-cycle strobe plus data.

---
 rtl/debug_input_pkg.sv | 38 +++
 rtl/debug_input_fifo.sv | 73 +++++++
 rtl/debug_input.sv | 130 +++++++++++++
 tb/tb_debug_input.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/debug_input_pkg.sv
// Shared definitions for the debug input channel: register map, STATUS
// bit layout and the level-saturation helper. The same constants are used by
// the debug output block and the firmware headers, so keep them in sync.
package debug_input_pkg;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned LVL_W     = 4;
    localparam int unsigned CNT_MAX_W = 9;   // wide enough for count at DEPTH = 256
    localparam int unsigned LVL_MAX   = 15;

    // Register addresses (i_wb_adr)
    localparam logic DBG_REG_DATA   = 1'b0;
    localparam logic DBG_REG_STATUS = 1'b1;

    // STATUS bit positions
    localparam int unsigned DBG_ST_NEMPTY  = 0;
    localparam int unsigned DBG_ST_FULL    = 1;
    localparam int unsigned DBG_ST_OVF     = 2;
    localparam int unsigned DBG_ST_LVL_LSB = 4;

    // STATUS register payload, MSB first: level[7:4], rsvd[3], ovf[2], full[1], nempty[0]
    typedef struct packed {
        logic [LVL_W-1:0] level;
        logic             rsvd;
        logic             ovf;
        logic             full;
        logic             nempty;
    } dbg_status_t;

    // Fill level clamped to what fits in the 4-bit STATUS field
    function automatic logic [LVL_W-1:0] sat_level(input logic [CNT_MAX_W-1:0] count);
        if (count > CNT_MAX_W'(LVL_MAX)) begin
            return LVL_W'(LVL_MAX);
        end
        return count[LVL_W-1:0];
    endfunction

endpackage

// File: rtl/debug_input_fifo.sv
// Byte FIFO for the debug input channel.
// The head entry is presented combinationally; the bus logic registers it.
// A pop is ignored when empty; a push is ignored when full unless a pop
// commits on the same edge, so a full FIFO can be read and written at once.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   push, wdata    push request and byte
//   pop            pop request
//   head_c         byte at the read pointer (valid when not empty)
//   count          number of stored entries, 0..DEPTH
//   full_c/empty_c occupancy flags derived from count
module debug_input_fifo
    import debug_input_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     pop,
    output logic [DATA_W-1:0]        head_c,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full_c,
    output logic                     empty_c
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push_c;
    logic              do_pop_c;

    // Qualify requests against occupancy
    always_comb begin
        full_c    = (count == (AW+1)'(DEPTH));
        empty_c   = (count == '0);
        do_pop_c  = pop & ~empty_c;
        do_push_c = push & (~full_c | do_pop_c);
        head_c    = mem[rd_ptr];
    end

    // Storage; contents need no reset since the pointers define validity
    always_ff @(posedge clk) begin
        if (do_push_c) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push_c, do_pop_c})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/debug_input.sv
// Host-to-CPU debug byte channel. Bytes arrive as strobe + data, are buffered
// in a FIFO, and are drained by the CPU over an 8-bit Wishbone slave.
// Optional macro: DEBUG_INPUT_IRQ_EN enables the level interrupt o_irq.
// Ports:
//   i_wb_clk, i_wb_rst_n        clock, asynchronous active-low reset
//   i_wb_adr                    0 = DATA, 1 = STATUS
//   i_wb_dat, i_wb_we           write data / write enable
//   i_wb_cyc, i_wb_stb          bus cycle / strobe
//   o_wb_rdt, o_wb_ack          registered read data and single-cycle ack
//   i_debug_strobe, i_debug_data  byte push interface
//   o_irq                       not_empty | overflow (0 without the macro)
module debug_input
    import debug_input_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic              i_wb_clk,
    input  logic              i_wb_rst_n,
    input  logic              i_wb_adr,
    input  logic [DATA_W-1:0] i_wb_dat,
    input  logic              i_wb_we,
    input  logic              i_wb_cyc,
    input  logic              i_wb_stb,
    output logic [DATA_W-1:0] o_wb_rdt,
    output logic              o_wb_ack,
    input  logic              i_debug_strobe,
    input  logic [DATA_W-1:0] i_debug_data,
    output logic              o_irq
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DATA_W-1:0] head_c;
    logic [AW:0]       count;
    logic              full_c;
    logic              empty_c;
    logic              overflow;

    logic              access_c;
    logic              data_rd_c;
    logic              stat_rd_c;
    logic              stat_wr_c;
    logic              ovf_set_c;
    logic              ovf_clr_c;
    dbg_status_t       status_c;
    logic [DATA_W-1:0] rdt_next_c;
    logic              unused_c;

    debug_input_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (i_wb_clk),
        .rst_n   (i_wb_rst_n),
        .push    (i_debug_strobe),
        .wdata   (i_debug_data),
        .pop     (data_rd_c),
        .head_c  (head_c),
        .count   (count),
        .full_c  (full_c),
        .empty_c (empty_c)
    );

    // Bus decode; an access is the cycle whose edge raises ack
    always_comb begin
        access_c  = i_wb_cyc & i_wb_stb & ~o_wb_ack;
        data_rd_c = access_c & ~i_wb_we & (i_wb_adr == DBG_REG_DATA);
        stat_rd_c = access_c & ~i_wb_we & (i_wb_adr == DBG_REG_STATUS);
        stat_wr_c = access_c &  i_wb_we & (i_wb_adr == DBG_REG_STATUS);
        // A same-edge DATA read of a full FIFO makes room, so no drop
        ovf_set_c = i_debug_strobe & full_c & ~data_rd_c;
        ovf_clr_c = stat_wr_c & i_wb_dat[DBG_ST_OVF];
    end

    // STATUS snapshot uses pre-edge FIFO state
    always_comb begin
        status_c        = '0;
        status_c.nempty = ~empty_c;
        status_c.full   = full_c;
        status_c.ovf    = overflow;
        status_c.rsvd   = 1'b0;
        status_c.level  = sat_level(CNT_MAX_W'(count));
    end

    // Read mux; an empty DATA read returns zero
    always_comb begin
        rdt_next_c = '0;
        if (data_rd_c && !empty_c) begin
            rdt_next_c = head_c;
        end else if (stat_rd_c) begin
            rdt_next_c = status_c;
        end
    end

    // Ack, read data and sticky overflow
    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            o_wb_ack <= 1'b0;
            o_wb_rdt <= '0;
            overflow <= 1'b0;
        end else begin
            o_wb_ack <= access_c;
            if (access_c) begin
                o_wb_rdt <= rdt_next_c;
            end
            // Set has priority over a same-edge clear
            if (ovf_set_c) begin
                overflow <= 1'b1;
            end else if (ovf_clr_c) begin
                overflow <= 1'b0;
            end
        end
    end

`ifdef DEBUG_INPUT_IRQ_EN
    // Level interrupt, one cycle behind the state that causes it
    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            o_irq <= 1'b0;
        end else begin
            o_irq <= ~empty_c | overflow;
        end
    end
`else
    assign o_irq = 1'b0;
`endif

    // Only the overflow-clear bit of the write data is meaningful
    assign unused_c = ^{i_wb_dat[DATA_W-1:DBG_ST_OVF+1], i_wb_dat[DBG_ST_OVF-1:0]};

endmodule

// File: tb/tb_debug_input.sv
// Testbench for debug_input: directed scenarios plus randomized traffic,
// checked against a queue-based model of the channel.
module tb_debug_input;

    localparam int DEPTH = 16;
`ifdef DEBUG_INPUT_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       adr    = 1'b0;
    logic [7:0] wdat   = 8'h00;
    logic       we     = 1'b0;
    logic       cyc    = 1'b0;
    logic       stb    = 1'b0;
    logic       strobe = 1'b0;
    logic [7:0] ddata  = 8'h00;
    logic [7:0] rdt;
    logic       ack;
    logic       irq;

    // Model state
    logic [7:0] m_q[$];
    bit         m_ovf = 1'b0;
    bit         m_ack = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    debug_input #(.DEPTH(DEPTH)) dut (
        .i_wb_clk       (clk),
        .i_wb_rst_n     (rst_n),
        .i_wb_adr       (adr),
        .i_wb_dat       (wdat),
        .i_wb_we        (we),
        .i_wb_cyc       (cyc),
        .i_wb_stb       (stb),
        .o_wb_rdt       (rdt),
        .o_wb_ack       (ack),
        .i_debug_strobe (strobe),
        .i_debug_data   (ddata),
        .o_irq          (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] m_status(input int sz, input bit ovf);
        int lvl;
        lvl = (sz > 15) ? 15 : sz;
        return 8'(lvl * 16 + (ovf ? 4 : 0) + (sz == DEPTH ? 2 : 0) + (sz != 0 ? 1 : 0));
    endfunction

    // One clock of stimulus; model update and checks of ack/irq/read data
    task automatic step(input bit s, input logic [7:0] d, input bit bus, input bit a,
                        input bit w, input logic [7:0] wd, output logic [7:0] got);
        int         sz;
        bit         acc;
        bit         rd;
        bit         set;
        bit         clr;
        bit         eirq;
        logic [7:0] erdt;
        @(negedge clk);
        strobe = s; ddata = d; cyc = bus; stb = bus; adr = a; we = w; wdat = wd;
        sz   = m_q.size();
        acc  = bus && !m_ack;
        rd   = acc && !w;
        eirq = IRQ_EN && (sz != 0 || m_ovf);
        erdt = 8'h00;
        if (rd) erdt = a ? m_status(sz, m_ovf) : (sz != 0 ? m_q[0] : 8'h00);
        if (rd && !a && sz != 0) void'(m_q.pop_front());
        set = 1'b0;
        if (s) begin
            if (m_q.size() < DEPTH) m_q.push_back(d);
            else set = 1'b1;
        end
        clr = acc && w && a && wd[2];
        if (set) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        m_ack = acc;
        @(posedge clk);
        #1;
        chk("ack", 8'(ack), 8'(acc));
        chk("irq", 8'(irq), 8'(eirq));
        if (rd) chk(a ? "status_rd" : "data_rd", rdt, erdt);
        got = rdt;
    endtask

    task automatic idle();
        logic [7:0] g;
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, g);
    endtask

    task automatic push(input logic [7:0] d);
        logic [7:0] g;
        step(1'b1, d, 1'b0, 1'b0, 1'b0, 8'h00, g);
    endtask

    // Read access followed by an idle cycle so ack returns low
    task automatic rd_reg(input bit a, output logic [7:0] got);
        step(1'b0, 8'h00, 1'b1, a, 1'b0, 8'h00, got);
        idle();
    endtask

    task automatic wr_status(input logic [7:0] d);
        logic [7:0] g;
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, d, g);
        idle();
    endtask

    initial begin
        logic [7:0] g;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ack", 8'(ack), 8'h00);
        chk("reset_rdt", rdt, 8'h00);
        chk("reset_irq", 8'(irq), 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Empty reads
        rd_reg(1'b1, g); chk("empty_status", g, 8'h00);
        rd_reg(1'b0, g); chk("empty_data", g, 8'h00);
        rd_reg(1'b1, g); chk("empty_status2", g, 8'h00);

        // Two pushes, then drain
        push(8'hA5);
        push(8'h3C);
        rd_reg(1'b1, g); chk("two_status", g, 8'h21);
        rd_reg(1'b0, g); chk("two_data0", g, 8'hA5);
        rd_reg(1'b0, g); chk("two_data1", g, 8'h3C);
        rd_reg(1'b1, g); chk("two_status_end", g, 8'h00);

        // Overfill by one, drain, clear overflow
        for (int i = 0; i < 17; i++) push(8'(i));
        rd_reg(1'b1, g); chk("ovf_status", g, 8'hF7);
        for (int i = 0; i < 16; i++) begin
            rd_reg(1'b0, g); chk("ovf_drain", g, 8'(i));
        end
        rd_reg(1'b1, g); chk("drained_status", g, 8'h04);
        wr_status(8'h04);
        rd_reg(1'b1, g); chk("cleared_status", g, 8'h00);

        // Full FIFO: read and push on the same edge
        for (int i = 0; i < 16; i++) push(8'(8'h40 + i));
        step(1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 8'h00, g);
        chk("full_pushpop_head", g, 8'h40);
        idle();
        rd_reg(1'b1, g); chk("full_pushpop_status", g, 8'hF3);
        for (int i = 1; i < 16; i++) begin
            rd_reg(1'b0, g); chk("full_pushpop_drain", g, 8'(8'h40 + i));
        end
        rd_reg(1'b0, g); chk("full_pushpop_last", g, 8'h77);

        // Empty FIFO: read and push on the same edge
        step(1'b1, 8'h99, 1'b1, 1'b0, 1'b0, 8'h00, g);
        chk("empty_pushpop_rdt", g, 8'h00);
        idle();
        rd_reg(1'b1, g); chk("empty_pushpop_status", g, 8'h11);
        rd_reg(1'b0, g); chk("empty_pushpop_data", g, 8'h99);

        // Overflow set and clear on the same edge: set wins
        for (int i = 0; i < 16; i++) push(8'(i));
        step(1'b1, 8'hEE, 1'b1, 1'b1, 1'b1, 8'h04, g);
        idle();
        rd_reg(1'b1, g); chk("set_beats_clear", g, 8'hF7);
        for (int i = 0; i < 16; i++) rd_reg(1'b0, g);
        wr_status(8'hFB);
        rd_reg(1'b1, g); chk("clear_needs_bit2", g, 8'h04);
        wr_status(8'h04);

        // Interrupt follows the occupancy one cycle later
        push(8'h5A);
        idle();
        chk("irq_after_push", 8'(irq), 8'(IRQ_EN));
        rd_reg(1'b0, g); chk("irq_byte", g, 8'h5A);
        idle();
        chk("irq_after_drain", 8'(irq), 8'h00);

        // Randomized traffic: push-heavy then drain-heavy
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) < ((i < 300) ? 3 : 1), 8'($urandom),
                 $urandom_range(0, 2) != 0, 1'($urandom), $urandom_range(0, 4) == 0,
                 8'($urandom), g);
        end

        // Reset in the middle of an access with 5 entries stored
        idle();
        idle();
        for (int i = 0; i < 16; i++) rd_reg(1'b0, g);
        wr_status(8'h04);
        for (int i = 0; i < 5; i++) push(8'(8'hC0 + i));
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, g);
        chk("pre_reset_status", g, 8'h51);
        rst_n = 1'b0; strobe = 1'b1; ddata = 8'hDD; cyc = 1'b0; stb = 1'b0;
        #1;
        chk("reset_mid_ack", 8'(ack), 8'h00);
        chk("reset_mid_rdt", rdt, 8'h00);
        chk("reset_mid_irq", 8'(irq), 8'h00);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1; strobe = 1'b0;
        m_q.delete();
        m_ovf = 1'b0;
        m_ack = 1'b0;
        rd_reg(1'b0, g); chk("post_reset_data", g, 8'h00);
        rd_reg(1'b1, g); chk("post_reset_status", g, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
